// File: rtl/key_mmio_responder_pkg.sv
// Shared key I/O definitions: bus width, register addresses and KCTRL field
// positions. MEM-stage address decode and WB display logic use the same values.
package key_mmio_responder_pkg;

  localparam int unsigned KEY_DBITS = 32;
  localparam int unsigned NUM_KEYS  = 4;

  localparam logic [31:0] KEY_ADDR_KDATA = 32'hFFFF_F080;
  localparam logic [31:0] KEY_ADDR_KCTRL = 32'hFFFF_F084;

  // KCTRL layout: [3:0] sticky press flags, [7:4] sticky overrun flags.
  localparam int unsigned PRESS_LSB = 0;
  localparam int unsigned OVR_LSB   = 4;

  function automatic logic [7:0] kctrl_pack(input logic [3:0] press,
                                            input logic [3:0] ovr);
    logic [7:0] v;
    v = '0;
    v[PRESS_LSB +: 4] = press;
    v[OVR_LSB +: 4]   = ovr;
    return v;
  endfunction

endpackage

// File: rtl/key_mmio_responder_debounce.sv
// Single-key synchronizer and debouncer. The raw active-low key passes through
// two flops; a new pressed level is accepted only after it has been seen for
// DEBOUNCE_CYCLES consecutive cycles. press_o pulses on the cycle whose clock
// edge moves the accepted state from released to pressed.
module key_debounce
  import key_mmio_responder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic state_o,
  output logic press_o
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level;

  // Two-flop synchronizer, reset to the released (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles the synchronized level differs from the accepted one.
  always_comb begin
    level   = ~sync2_q;
    state_d = state_q;
    cnt_d   = '0;
    press_o = 1'b0;
    if (level != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ~state_q;
        press_o = ~state_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Accepted level and run counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/key_mmio_responder.sv
// Memory-mapped responder for the four board pushbuttons. Debounces each key,
// keeps sticky press/overrun flags (write-1-to-clear) and answers MEM-stage
// loads with registered data one cycle after the request.
module key_mmio_responder
  import key_mmio_responder_pkg::*;
#(
  parameter int unsigned      DBITS           = KEY_DBITS,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(KEY_ADDR_KDATA),
  parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(KEY_ADDR_KCTRL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic             rd_en,
  input  logic [DBITS-1:0] rd_addr,
  output logic [DBITS-1:0] rd_data,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wr_addr,
  input  logic [DBITS-1:0] wr_data,
  output logic [3:0]       key_state
);

  logic [NUM_KEYS-1:0] press_ev;
  logic [3:0]          press_q, press_d;
  logic [3:0]          ovr_q, ovr_d;
  logic [3:0]          clr_press, clr_ovr;
  logic                rd_valid_q, rd_valid_d;
  logic [DBITS-1:0]    rd_data_q, rd_data_d;
  logic                unused_wdata_hi;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .key_n_i(KEY[i]),
      .state_o(key_state[i]),
      .press_o(press_ev[i])
    );
  end

  assign unused_wdata_hi = ^wr_data[DBITS-1:8];

  // Sticky flags: a press event always wins over a same-cycle clear of its flag,
  // and only counts as an overrun when the old flag is not being cleared.
  always_comb begin
    clr_press = '0;
    clr_ovr   = '0;
    if (wr_en && (wr_addr == ADDR_KCTRL)) begin
      clr_press = wr_data[PRESS_LSB +: 4];
      clr_ovr   = wr_data[OVR_LSB +: 4];
    end
    press_d = (press_q & ~clr_press) | press_ev;
    ovr_d   = (ovr_q & ~clr_ovr) | (press_ev & press_q & ~clr_press);
  end

  // Read decode; data is sampled from the registers as they stand this cycle.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = '0;
    if (rd_en && (rd_addr == ADDR_KDATA)) begin
      rd_valid_d     = 1'b1;
      rd_data_d[3:0] = key_state;
    end else if (rd_en && (rd_addr == ADDR_KCTRL)) begin
      rd_valid_d     = 1'b1;
      rd_data_d[7:0] = kctrl_pack(press_q, ovr_q);
    end
  end

  // Flag and read-response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_q    <= '0;
      ovr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      press_q    <= press_d;
      ovr_q      <= ovr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
